// File: rtl/scratch_stack_ctrl.sv
// Register-cached operand stack: TOS/NOS in flops, deeper entries spilled to an external synchronous RAM.
// Spills take one WR cycle and refills take three read cycles; cmd_ready is high only while idle.
module scratch_stack_ctrl #(
   parameter int AW = 8,
   parameter int DW = 32
) (
   input  logic          CLK,
   input  logic          resetn,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [2:0]    cmd_op,
   input  logic [DW-1:0] cmd_data,
   output logic [DW-1:0] tos,
   output logic [DW-1:0] nos,
   output logic [AW+1:0] depth,
   output logic          err_overflow,
   output logic          err_underflow,
   input  logic          err_clr,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_wdata,
   output logic          ram_wen,
   input  logic [DW-1:0] ram_rdata
);

   localparam logic [2:0] OP_PUSH  = 3'd0;
   localparam logic [2:0] OP_POP   = 3'd1;
   localparam logic [2:0] OP_REPL2 = 3'd2;
   localparam logic [2:0] OP_DUP   = 3'd3;
   localparam logic [2:0] OP_OVER  = 3'd4;
   localparam logic [2:0] OP_SWAP  = 3'd5;

   localparam int            MAX_I     = (1 << AW) + 2;
   localparam logic [AW+1:0] MAX_DEPTH = MAX_I[AW+1:0];
   localparam logic [AW+1:0] D_ZERO    = '0;
   localparam logic [AW+1:0] D_ONE     = 1;
   localparam logic [AW+1:0] D_TWO     = 2;
   localparam logic [AW:0]   S_ONE     = 1;

   typedef enum logic [2:0] {IDLE, WR, RD0, RD1, RD2} state_t;

   state_t        state, state_nxt;
   logic [DW-1:0] tos_nxt, nos_nxt, wdata_nxt;
   logic [AW+1:0] depth_nxt;
   logic [AW:0]   sp, sp_nxt, sp_dec;
   logic [AW-1:0] addr_nxt;
   logic          ovf_set, unf_set;
   logic          is_empty, lt2, is_full, has_below;

   assign cmd_ready = (state == IDLE);
   // Write enable is decoded from state so an asynchronous reset removes it at once.
   assign ram_wen   = (state == WR);

   assign is_empty  = (depth == D_ZERO);
   assign lt2       = (depth < D_TWO);
   assign is_full   = (depth == MAX_DEPTH);
   assign has_below = (depth > D_TWO);
   assign sp_dec    = sp - S_ONE;

   always_comb begin
      state_nxt = state;
      tos_nxt   = tos;
      nos_nxt   = nos;
      depth_nxt = depth;
      sp_nxt    = sp;
      addr_nxt  = ram_addr;
      wdata_nxt = ram_wdata;
      ovf_set   = 1'b0;
      unf_set   = 1'b0;
      case (state)
         IDLE: begin
            if (cmd_valid) begin
               case (cmd_op)
                  OP_PUSH, OP_DUP, OP_OVER: begin
                     if ((cmd_op == OP_DUP && is_empty) || (cmd_op == OP_OVER && lt2)) begin
                        unf_set = 1'b1;
                     end else if (is_full) begin
                        ovf_set = 1'b1;
                     end else begin
                        if (cmd_op == OP_PUSH)     tos_nxt = cmd_data;
                        else if (cmd_op == OP_OVER) tos_nxt = nos;
                        nos_nxt   = tos;
                        depth_nxt = depth + D_ONE;
                        if (!lt2) begin
                           addr_nxt  = sp[AW-1:0];
                           wdata_nxt = nos;
                           state_nxt = WR;
                        end
                     end
                  end
                  OP_POP, OP_REPL2: begin
                     if ((cmd_op == OP_POP && is_empty) || (cmd_op == OP_REPL2 && lt2)) begin
                        unf_set = 1'b1;
                     end else begin
                        tos_nxt   = (cmd_op == OP_POP) ? nos : cmd_data;
                        depth_nxt = depth - D_ONE;
                        if (has_below) begin
                           sp_nxt    = sp_dec;
                           addr_nxt  = sp_dec[AW-1:0];
                           state_nxt = RD0;
                        end else begin
                           nos_nxt = '0;
                        end
                     end
                  end
                  OP_SWAP: begin
                     if (lt2) begin
                        unf_set = 1'b1;
                     end else begin
                        tos_nxt = nos;
                        nos_nxt = tos;
                     end
                  end
                  default: ;
               endcase
            end
         end
         WR: begin
            sp_nxt    = sp + S_ONE;
            state_nxt = IDLE;
         end
         RD0: state_nxt = RD1;
         RD1: state_nxt = RD2;
         RD2: begin
            nos_nxt   = ram_rdata;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge resetn) begin
      if (!resetn) begin
         state         <= IDLE;
         tos           <= '0;
         nos           <= '0;
         depth         <= '0;
         sp            <= '0;
         ram_addr      <= '0;
         ram_wdata     <= '0;
         err_overflow  <= 1'b0;
         err_underflow <= 1'b0;
      end else begin
         state         <= state_nxt;
         tos           <= tos_nxt;
         nos           <= nos_nxt;
         depth         <= depth_nxt;
         sp            <= sp_nxt;
         ram_addr      <= addr_nxt;
         ram_wdata     <= wdata_nxt;
         // A fresh error on the same edge as err_clr keeps the flag set.
         err_overflow  <= ovf_set | (err_overflow & ~err_clr);
         err_underflow <= unf_set | (err_underflow & ~err_clr);
      end
   end

endmodule

// File: tb/tb_scratch_stack_ctrl.sv
// Directed bench for scratch_stack_ctrl: a queue-based stack model predicts each result, a scoreboard compares.
module tb_scratch_stack_ctrl;
   localparam int AW   = 8;
   localparam int DW   = 32;
   localparam int MAXD = (1 << AW) + 2;

   logic          CLK, resetn, cmd_valid, cmd_ready, err_clr;
   logic [2:0]    cmd_op;
   logic [DW-1:0] cmd_data, tos, nos, ram_wdata, ram_rdata;
   logic [AW+1:0] depth;
   logic          err_overflow, err_underflow, ram_wen;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] mem [0:(1<<AW)-1];

   typedef struct {
      logic [DW-1:0] tos;
      logic [DW-1:0] nos;
      int            depth;
      logic          eo;
      logic          eu;
      int            lat;
   } exp_t;

   exp_t          sb[$];
   logic [DW-1:0] stk[$];
   logic          m_eo, m_eu;
   int            total = 0;
   int            bad = 0;
   int            wen_cnt, busy_cnt, wr_addr, acc_depth;
   logic [DW-1:0] wr_data;
   logic          addr_held;
   logic [AW-1:0] busy_addr0;

   scratch_stack_ctrl #(.AW(AW), .DW(DW)) dut (
      .CLK(CLK), .resetn(resetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_data(cmd_data), .tos(tos), .nos(nos), .depth(depth),
      .err_overflow(err_overflow), .err_underflow(err_underflow), .err_clr(err_clr),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wen(ram_wen), .ram_rdata(ram_rdata)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   always_ff @(posedge CLK) begin
      if (ram_wen) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic model(input logic [2:0] op, input logic [DW-1:0] d, input logic clr, output int lat);
      int            n = stk.size();
      logic          eo = 1'b0;
      logic          eu = 1'b0;
      logic [DW-1:0] t;
      lat = 1;
      case (op)
         3'd0: if (n == MAXD) eo = 1'b1;
               else begin stk.push_back(d); if (n >= 2) lat = 2; end
         3'd3: if (n == 0) eu = 1'b1; else if (n == MAXD) eo = 1'b1;
               else begin stk.push_back(stk[n-1]); if (n >= 2) lat = 2; end
         3'd4: if (n < 2) eu = 1'b1; else if (n == MAXD) eo = 1'b1;
               else begin stk.push_back(stk[n-2]); lat = 2; end
         3'd5: if (n < 2) eu = 1'b1;
               else begin t = stk[n-1]; stk[n-1] = stk[n-2]; stk[n-2] = t; end
         3'd1: if (n == 0) eu = 1'b1;
               else begin void'(stk.pop_back()); if (n > 2) lat = 4; end
         3'd2: if (n < 2) eu = 1'b1;
               else begin
                  void'(stk.pop_back()); void'(stk.pop_back()); stk.push_back(d);
                  if (n > 2) lat = 4;
               end
         default: ;
      endcase
      m_eo = eo | (m_eo & ~clr);
      m_eu = eu | (m_eu & ~clr);
   endtask

   task automatic do_cmd(input logic [2:0] op, input logic [DW-1:0] d, input logic clr, input string tag);
      exp_t e;
      int   lat, got_lat, n;
      model(op, d, clr, lat);
      n       = stk.size();
      e.tos   = (n >= 1) ? stk[n-1] : '0;
      e.nos   = (n >= 2) ? stk[n-2] : '0;
      e.depth = n;
      e.eo    = m_eo;
      e.eu    = m_eu;
      e.lat   = lat;
      sb.push_back(e);
      @(negedge CLK);
      chk({tag, " ready"}, cmd_ready, 1);
      cmd_valid = 1'b1; cmd_op = op; cmd_data = d; err_clr = clr;
      @(posedge CLK); #1;
      cmd_valid = 1'b0; err_clr = 1'b0; cmd_data = '0;
      wen_cnt = 0; busy_cnt = 0; addr_held = 1'b1; got_lat = 1;
      busy_addr0 = ram_addr; acc_depth = depth;
      while (!cmd_ready && got_lat < 12) begin
         busy_cnt++;
         if (ram_wen) begin wen_cnt++; wr_addr = ram_addr; wr_data = ram_wdata; end
         if (ram_addr !== busy_addr0) addr_held = 1'b0;
         @(posedge CLK); #1;
         got_lat++;
      end
      e = sb.pop_front();
      chk({tag, " latency"}, got_lat, e.lat);
      chk({tag, " tos"}, tos, e.tos);
      chk({tag, " nos"}, nos, e.nos);
      chk({tag, " depth"}, depth, e.depth);
      chk({tag, " err_overflow"}, err_overflow, e.eo);
      chk({tag, " err_underflow"}, err_underflow, e.eu);
   endtask

   initial begin
      resetn = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0; err_clr = 1'b0;
      m_eo = 1'b0; m_eu = 1'b0;
      #22;
      chk("rst tos", tos, 0);
      chk("rst nos", nos, 0);
      chk("rst depth", depth, 0);
      chk("rst ram_wen", ram_wen, 0);
      chk("rst ram_addr", ram_addr, 0);
      chk("rst ram_wdata", ram_wdata, 0);
      chk("rst err_overflow", err_overflow, 0);
      chk("rst err_underflow", err_underflow, 0);
      @(negedge CLK); resetn = 1'b1;

      do_cmd(3'd0, 32'h11, 1'b0, "push11");
      chk("push11 wen", wen_cnt, 0);
      do_cmd(3'd0, 32'h22, 1'b0, "push22");
      do_cmd(3'd0, 32'h33, 1'b0, "push33");
      chk("push33 wen count", wen_cnt, 1);
      chk("push33 spill addr", wr_addr, 0);
      chk("push33 spill data", wr_data, 32'h11);

      do_cmd(3'd1, '0, 1'b0, "pop_refill");
      chk("pop busy cycles", busy_cnt, 3);
      chk("pop addr held", addr_held, 1);
      chk("pop addr", busy_addr0, 0);
      chk("pop depth at accept", acc_depth, 2);
      chk("pop no write", wen_cnt, 0);

      do_cmd(3'd0, 32'h33, 1'b0, "push33b");
      do_cmd(3'd2, 32'h99, 1'b0, "repl2_refill");
      do_cmd(3'd5, '0, 1'b0, "swap");
      do_cmd(3'd3, '0, 1'b0, "dup");
      do_cmd(3'd4, '0, 1'b0, "over");
      do_cmd(3'd2, 32'h44, 1'b0, "repl2b");
      while (stk.size() > 0) do_cmd(3'd1, '0, 1'b0, "drain1");

      do_cmd(3'd1, '0, 1'b1, "pop_empty_clr");
      do_cmd(3'd3, '0, 1'b0, "dup_empty");
      do_cmd(3'd6, '0, 1'b1, "rsv_clr");
      do_cmd(3'd0, 32'h7, 1'b0, "push7");
      do_cmd(3'd4, '0, 1'b0, "over_d1");
      do_cmd(3'd5, '0, 1'b0, "swap_d1");
      do_cmd(3'd2, 32'h55, 1'b0, "repl2_d1");
      do_cmd(3'd7, '0, 1'b0, "rsv7");
      do_cmd(3'd3, '0, 1'b1, "dup_d1_clr");
      do_cmd(3'd1, '0, 1'b0, "pop_d2");
      do_cmd(3'd1, '0, 1'b0, "pop_d1");

      for (int i = 0; i < MAXD; i++) do_cmd(3'd0, 32'h1000 + i, 1'b0, "fill");
      do_cmd(3'd0, 32'hAB, 1'b0, "push_ovf");
      chk("push_ovf no write", wen_cnt, 0);
      do_cmd(3'd3, '0, 1'b0, "dup_ovf");
      do_cmd(3'd4, '0, 1'b0, "over_ovf");
      do_cmd(3'd6, '0, 1'b1, "rsv_clr2");
      while (stk.size() > 0) do_cmd(3'd1, '0, 1'b0, "drain2");

      do_cmd(3'd0, 32'h1, 1'b0, "pre1");
      do_cmd(3'd0, 32'h2, 1'b0, "pre2");
      do_cmd(3'd0, 32'h3, 1'b0, "pre3");
      @(negedge CLK);
      cmd_valid = 1'b1; cmd_op = 3'd1;
      @(posedge CLK); #1;
      cmd_valid = 1'b0;
      @(posedge CLK); #2;
      resetn = 1'b0;
      #1;
      chk("midrst tos", tos, 0);
      chk("midrst nos", nos, 0);
      chk("midrst depth", depth, 0);
      chk("midrst ram_wen", ram_wen, 0);
      chk("midrst ram_addr", ram_addr, 0);
      chk("midrst ram_wdata", ram_wdata, 0);
      chk("midrst err_overflow", err_overflow, 0);
      chk("midrst err_underflow", err_underflow, 0);
      stk.delete();
      m_eo = 1'b0; m_eu = 1'b0;
      @(negedge CLK); resetn = 1'b1;
      do_cmd(3'd0, 32'h5, 1'b0, "push5");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
